rot_frame_sequencer: RTL and testbench
======================================

# rot_frame_sequencer

Hardware driver for the image-rotation adapter: it plays the role the adapter's host normally plays. It reads a frame from a source memory and streams it into the adapter in store mode. It then switches the adapter to rotate mode and captures the rotated pixel stream into a downstream valid/eol/eof stream. It sits between the frame source memory and the display/output path, with the adapter as its only peer.

## Interface
Parameters:
- IMG_W, 256, source image width in pixels
- IMG_H, 256, source image height in pixels
- PIX_W, 24, pixel width (RGB888)
- GAP_CYCLES, 2, idle cycles between end of load and assertion of rotate mode (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on frame completion
- src_rd  out  1  source memory read strobe
- src_addr  out  clog2(IMG_W*IMG_H)  source read address, raster order
- src_data  in  PIX_W  source read data, valid exactly 1 cycle after src_rd
- ad_rst  out  1  adapter reset, active-high
- ad_mode  out  1  adapter mode: 0 store, 1 rotate
- ad_data_in  out  PIX_W  pixel to adapter
- ad_data_out  in  PIX_W  rotated pixel from adapter
- ad_jump_out  in  1  adapter end-of-row marker
- ad_output_done  in  1  adapter last-pixel marker
- m_valid  out  1  captured pixel valid; no backpressure
- m_data  out  PIX_W  captured rotated pixel
- m_eol  out  1  end of rotated row, qualified by m_valid
- m_eof  out  1  last pixel of frame, qualified by m_valid
- err_len  out  1  sticky stream-length error, cleared by start

## Operation
- N = IMG_W*IMG_H. Pixel counter is clog2(N)+1 bits so that it holds N.
- States:
  - IDLE: ad_rst=1, ad_mode=0, src_rd=0. On start, go to PRIME.
  - PRIME: 1 cycle. src_rd=1, src_addr=0. ad_rst stays 1. Go to LOAD.
  - LOAD: exactly N cycles. ad_rst=0, ad_mode=0.
    - ad_data_in at LOAD cycle k equals source pixel k, registered from src_data.
    - src_rd=1 with src_addr=k+1 for k=0..N-2; src_rd=0 at k=N-1.
    - After cycle N-1, go to GAP.
  - GAP: GAP_CYCLES cycles. ad_mode=0, ad_data_in held at 0. Go to ROTATE.
  - ROTATE: ad_mode=1.
    - Capture stage registers ad_data_out, ad_jump_out and ad_output_done.
    - m_valid=1 on each cycle after ROTATE entry, up to and including the cycle that carries m_eof.
    - Leave ROTATE when ad_output_done is sampled high, or when N pixels have been captured without it (timeout). Either way, go to DONE.
  - DONE: 1 cycle. done=1, ad_mode=0. Go to IDLE.
- start outside IDLE is ignored. start in the same cycle as DONE is also ignored.
- Reset mid-frame: all state is abandoned and the block returns to IDLE. ad_rst=1, and no m_valid, m_eof or done is emitted for the aborted frame.
- Reset values: busy=0, done=0, src_rd=0, src_addr=0, ad_rst=1, ad_mode=0, ad_data_in=0, m_valid=0, m_data=0, m_eol=0, m_eof=0, err_len=0.

## Timing
- start at cycle 0 → PRIME at cycle 1 → LOAD cycles 2..N+1 → GAP → first ROTATE cycle at N+2+GAP_CYCLES.
- Capture latency: 1 cycle. An adapter output sampled at cycle t appears on m_* at cycle t+1.
- done asserts in the cycle after the m_eof beat, or in the cycle after the timeout.
- All outputs are registered. There is no combinational path from adapter inputs to m_*.

## Configuration
- ROT_SEQ_LENCHK_EN defined: length checker is compiled in. err_len is set if any of the following occurs:
  - m_eol appears at a pixel index not ≡ IMG_H-1 (mod IMG_H). The rotated row length is IMG_H.
  - m_eof appears at an index other than N-1.
  - The ROTATE timeout fires.
- Not defined: checker logic is absent and err_len is tied to 0. The timeout exit still exists.

## Structure
- Shared package/header rot_pkg: state encoding constants, PIX_W default, and the N and address-width derivations. These are shared with the adapter and its bench.
- One sub-module, rot_stream_capture: the capture register stage, pixel/row counters and the ROT_SEQ_LENCHK_EN checker. The FSM, source addressing and load path stay in the top.

## Test plan
- IMG_W=IMG_H=4, source = 0x000000..0x00000F, loopback adapter model → ad_data_in shows 0x00..0x0F on LOAD cycles 0..15; 16 m_valid beats; m_eol on beats 3,7,11,15; m_eof on beat 15; done 1 cycle later; err_len=0.
- Default 256x256 with a golden 90° adapter model → m_data sequence matches the reference rotated image; 256 m_eol beats; done exactly once.
- Model suppresses output_done → ROTATE times out after 16 beats (4x4 case), done pulses, and err_len=1 (with ROT_SEQ_LENCHK_EN defined) or 0 (without).
- Model emits jump_out on beat 2 → err_len=1 from the following cycle, sticky until the next start.
- rst asserted at LOAD cycle 7 → next cycle: busy=0, ad_rst=1, src_rd=0, no done; a new start then replays the full frame correctly.
- start pulses during LOAD and ROTATE → ignored, and the frame completes with exactly one done.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation adapter, its driver and benches.
// State encoding, default pixel width and frame-size derivations.
package rot_pkg;

  localparam int PIX_W_DEF = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_LOAD,
    S_GAP,
    S_ROTATE,
    S_DONE
  } rot_state_e;

  function automatic int pix_count(input int w, input int h);
    return w * h;
  endfunction

  function automatic int addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  // Wide enough to hold n itself, not just n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) + 1 : 2;
  endfunction

endpackage

// File: rtl/rot_stream_capture.sv
// Registers the adapter's rotated stream onto m_* and counts beats.
// Optional ROT_SEQ_LENCHK_EN adds the sticky row/frame length checker.
module rot_stream_capture
  import rot_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = PIX_W_DEF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cap_en,
  input  logic [PIX_W-1:0] ad_data_out,
  input  logic             ad_jump_out,
  input  logic             ad_output_done,
  output logic             m_valid,
  output logic [PIX_W-1:0] m_data,
  output logic             m_eol,
  output logic             m_eof,
  output logic             err_len,
  output logic             stop
);

  localparam int N  = pix_count(IMG_W, IMG_H);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] NC = CW'(N);

  logic [CW-1:0] pcnt;
  logic          take;

  // Stop once the eof beat is out, or after N beats with no eof.
  assign stop = (m_valid && m_eof) || (pcnt == NC);
  assign take = cap_en && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else begin
      if (clr)
        pcnt <= '0;
      else if (take)
        pcnt <= pcnt + CW'(1);
      m_valid <= take;
      m_eol   <= take && ad_jump_out;
      m_eof   <= take && ad_output_done;
      if (take)
        m_data <= ad_data_out;
    end
  end

`ifdef ROT_SEQ_LENCHK_EN
  localparam int HW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [HW-1:0] HL = HW'(IMG_H - 1);

  logic [HW-1:0] col;
  logic [HW-1:0] m_col;
  logic          bad_eol;
  logic          bad_eof;
  logic          tmo;

  assign bad_eol = m_valid && m_eol && (m_col != HL);
  assign bad_eof = m_valid && m_eof && (pcnt != NC);
  assign tmo     = cap_en && (pcnt == NC) && !(m_valid && m_eof);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      m_col   <= '0;
      err_len <= 1'b0;
    end else if (clr) begin
      col     <= '0;
      err_len <= 1'b0;
    end else begin
      if (take) begin
        m_col <= col;
        col   <= (col == HL) ? '0 : col + HW'(1);
      end
      if (bad_eol || bad_eof || tmo)
        err_len <= 1'b1;
    end
  end
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: rtl/rot_frame_sequencer.sv
// Drives the rotation adapter: loads a frame, then captures it rotated.
// Define ROT_SEQ_LENCHK_EN to build in the stream-length checker.
module rot_frame_sequencer
  import rot_pkg::*;
#(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int GAP_CYCLES = 2,
  localparam int AW        = addr_w(IMG_W, IMG_H)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             src_rd,
  output logic [AW-1:0]    src_addr,
  input  logic [PIX_W-1:0] src_data,
  output logic             ad_rst,
  output logic             ad_mode,
  output logic [PIX_W-1:0] ad_data_in,
  input  logic [PIX_W-1:0] ad_data_out,
  input  logic             ad_jump_out,
  input  logic             ad_output_done,
  output logic             m_valid,
  output logic [PIX_W-1:0] m_data,
  output logic             m_eol,
  output logic             m_eof,
  output logic             err_len
);

  localparam int N  = pix_count(IMG_W, IMG_H);
  localparam int CW = cnt_w(N);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int KW = (CW > GW) ? CW : GW;

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_PEN  = KW'(N - 2);
  localparam logic [KW-1:0] G_LAST = KW'(GAP_CYCLES - 1);

  rot_state_e    state;
  logic [KW-1:0] cnt;
  logic          cap_stop;
  logic          clr;
  logic          cap_en;

  assign clr    = (state == S_IDLE) && start;
  assign cap_en = (state == S_ROTATE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      src_rd     <= 1'b0;
      src_addr   <= '0;
      ad_rst     <= 1'b1;
      ad_mode    <= 1'b0;
      ad_data_in <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_PRIME;
            busy     <= 1'b1;
            src_rd   <= 1'b1;
            src_addr <= '0;
          end
        end
        S_PRIME: begin
          state      <= S_LOAD;
          cnt        <= '0;
          ad_rst     <= 1'b0;
          ad_data_in <= src_data;
          src_rd     <= (N > 1);
          src_addr   <= AW'(1);
        end
        S_LOAD: begin
          // Read data lands one cycle after its strobe.
          ad_data_in <= src_rd ? src_data : '0;
          if (cnt == K_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + KW'(1);
            if (cnt < K_PEN) begin
              src_rd   <= 1'b1;
              src_addr <= src_addr + AW'(1);
            end else begin
              src_rd <= 1'b0;
            end
          end
        end
        S_GAP: begin
          ad_data_in <= '0;
          if (cnt == G_LAST) begin
            state   <= S_ROTATE;
            cnt     <= '0;
            ad_mode <= 1'b1;
          end else begin
            cnt <= cnt + KW'(1);
          end
        end
        S_ROTATE: begin
          if (cap_stop) begin
            state   <= S_DONE;
            done    <= 1'b1;
            ad_mode <= 1'b0;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          ad_rst <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  rot_stream_capture #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W)
  ) u_cap (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .cap_en         (cap_en),
    .ad_data_out    (ad_data_out),
    .ad_jump_out    (ad_jump_out),
    .ad_output_done (ad_output_done),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_eol          (m_eol),
    .m_eof          (m_eof),
    .err_len        (err_len),
    .stop           (cap_stop)
  );

endmodule

// File: tb/tb_rot_frame_sequencer.sv
// Bench for rot_frame_sequencer with a behavioural adapter and source memory.
// Non-square 8x4 frame so width/height swaps show up.
module tb_rot_frame_sequencer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int G  = 2;
  localparam int PW = 24;
  localparam int AW = $clog2(N);
  localparam int R  = N + 2 + G;

`ifdef ROT_SEQ_LENCHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, src_rd, ad_rst, ad_mode;
  logic m_valid, m_eol, m_eof, err_len;
  logic ad_jump_out, ad_output_done;
  logic [AW-1:0] src_addr;
  logic [PW-1:0] src_data, ad_data_in, ad_data_out, m_data;

  logic [PW-1:0] img [N];
  logic [PW-1:0] abuf [N];
  int wp, rp;
  int jump_at = -1;
  bit rot_mode, suppress;
  int n_cmp = 0;
  int n_bad = 0;
  bit err_exp;

  always #5 clk = ~clk;

  rot_frame_sequencer #(
    .IMG_W      (W),
    .IMG_H      (H),
    .PIX_W      (PW),
    .GAP_CYCLES (G)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .src_rd         (src_rd),
    .src_addr       (src_addr),
    .src_data       (src_data),
    .ad_rst         (ad_rst),
    .ad_mode        (ad_mode),
    .ad_data_in     (ad_data_in),
    .ad_data_out    (ad_data_out),
    .ad_jump_out    (ad_jump_out),
    .ad_output_done (ad_output_done),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_eol          (m_eol),
    .m_eof          (m_eof),
    .err_len        (err_len)
  );

  // Source memory: data sampled by the driver at the edge after its strobe.
  assign src_data = src_rd ? img[src_addr] : '0;

  // Rotated-image index p reads source (H-1-p%H, p/H): 90 deg clockwise.
  function automatic int rot_src(input int p);
    return (H - 1 - p % H) * W + p / H;
  endfunction

  always @(posedge clk) begin
    if (ad_rst) begin
      wp <= 0;
      rp <= 0;
    end else if (!ad_mode) begin
      if (wp < N) begin
        abuf[wp] <= ad_data_in;
        wp <= wp + 1;
      end
    end else if (rp < N) begin
      rp <= rp + 1;
    end
  end

  always_comb begin
    ad_data_out = '0;
    ad_jump_out = 1'b0;
    ad_output_done = 1'b0;
    if (ad_mode && !ad_rst && rp < N) begin
      ad_data_out = abuf[rot_mode ? rot_src(rp) : rp];
      ad_jump_out = (rp % H == H - 1) || (rp == jump_at);
      ad_output_done = (rp == N - 1) && !suppress;
    end
  end

  task automatic run_frame(input bit rotm, input bit supp,
                           input int jat, input bit noise);
    logic [PW-1:0] ex [N];
    bit eolx [N];
    logic [7:0] got, want;
    int b, nz1, nz2, last;
    bit e_mv;
    for (int p = 0; p < N; p++)
      img[p] = PW'($urandom);
    rot_mode = rotm;
    suppress = supp;
    jump_at = jat;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (rotm) ex[c * H + (H - 1 - r)] = img[r * W + c];
        else ex[r * W + c] = img[r * W + c];
    for (int p = 0; p < N; p++)
      eolx[p] = (p % H == H - 1) || (p == jat);
    last = R + 2 + N;
    nz1 = $urandom_range(N + 1, 2);
    nz2 = $urandom_range(R + 1 + N, R);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    err_exp = 1'b0;
    for (int j = 1; j <= last; j++) begin
      start = noise && (j == nz1 || j == nz2);
      @(negedge clk);
      b = j - R - 1;
      e_mv = (b >= 0 && b < N);
      want = {j <= R + 1 + N, j == R + 1 + N, j <= N,
              j == 1 || j == last, j >= R && j <= R + N, e_mv,
              e_mv && eolx[e_mv ? b : 0],
              e_mv && b == N - 1 && !supp};
      got = {busy, done, src_rd, ad_rst, ad_mode, m_valid, m_eol, m_eof};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL ctrl j=%0d got %b want %b", j, got, want);
      end
      if (j <= N) begin
        n_cmp++;
        if (src_addr !== AW'(j - 1)) begin
          n_bad++;
          $display("FAIL src_addr j=%0d got %0d want %0d", j, src_addr, j - 1);
        end
      end
      if (j >= 2 && j <= N + 1) begin
        n_cmp++;
        if (ad_data_in !== img[j - 2]) begin
          n_bad++;
          $display("FAIL ld_data k=%0d got %h want %h", j - 2, ad_data_in, img[j - 2]);
        end
      end
      if (j >= N + 2 && j < R) begin
        n_cmp++;
        if (ad_data_in !== '0) begin
          n_bad++;
          $display("FAIL gap_data j=%0d got %h want 0", j, ad_data_in);
        end
      end
      if (e_mv) begin
        n_cmp++;
        if (m_data !== ex[b]) begin
          n_bad++;
          $display("FAIL m_data beat=%0d got %h want %h", b, m_data, ex[b]);
        end
      end
      n_cmp++;
      if (err_len !== err_exp) begin
        n_bad++;
        $display("FAIL err_len j=%0d got %b want %b", j, err_len, err_exp);
      end
      if (e_mv && eolx[b] && (b % H != H - 1)) err_exp = CHK;
      if (supp && b == N - 1) err_exp = CHK;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, src_rd, ad_rst, ad_mode, m_valid, m_eol, m_eof, err_len}
        !== 9'b000100000 || src_addr !== '0 || ad_data_in !== '0 || m_data !== '0) begin
      n_bad++;
      $display("FAIL reset_vals got %b/%0d/%h/%h want 000100000/0/0/0",
               {busy, done, src_rd, ad_rst, ad_mode, m_valid, m_eol, m_eof, err_len},
               src_addr, ad_data_in, m_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic test_loopback;
    run_frame(1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_rotate;
    repeat (3) run_frame(1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_timeout;
    run_frame(1'b1, 1'b1, -1, 1'b0);
  endtask

  task automatic test_jump_err;
    run_frame(1'b1, 1'b0, 2, 1'b0);
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, err_len} !== {1'b0, err_exp}) begin
        n_bad++;
        $display("FAIL err_sticky got %b want %b", {busy, err_len}, {1'b0, err_exp});
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    img[0] = '0;
    rot_mode = 1'b1;
    suppress = 1'b0;
    jump_at = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, src_rd, ad_rst, ad_mode, m_valid} !== 6'b000100) begin
      n_bad++;
      $display("FAIL mid_reset got %b want 000100",
               {busy, done, src_rd, ad_rst, ad_mode, m_valid});
    end
    @(posedge clk); #1 rst = 1'b0;
    err_exp = 1'b0;
    repeat (N + G + 8) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, m_valid, m_eof, ad_rst} !== 5'b00001) begin
        n_bad++;
        $display("FAIL post_reset got %b want 00001",
                 {busy, done, m_valid, m_eof, ad_rst});
      end
    end
    run_frame(1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_start_noise;
    repeat (2) run_frame(1'b1, 1'b0, -1, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_frame(1'b0, 1'b0, -1, 1'b0);
    run_frame(1'b1, 1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_rotate;
    test_timeout;
    test_jump_err;
    test_reset_mid_frame;
    test_start_noise;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
